aes_inv_mix_column_stage: RTL and testbench



---
 rtl/aes_inv_mix_column_stage_pkg.sv | 15 +
 rtl/aes_inv_mix_column_stage_mult_da.sv | 39 +++
 rtl/aes_inv_mix_column_stage.sv | 104 ++++++++++
 tb/tb_aes_inv_mix_column_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_mix_column_stage_pkg.sv
// Shared widths and state encoding for the AES inverse AddRoundKey/InvMixColumns stage.
package aes_inv_mix_column_stage_pkg;

    localparam int BLOCK_W   = 128;
    localparam int COL_W     = 32;
    localparam int NUM_COLS  = 4;
    localparam int COL_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/aes_inv_mix_column_stage_mult_da.sv
// InvMixColumns on one 32-bit column (row 0 in the MSB byte).
module AesMultDAFun
    import aes_inv_mix_column_stage_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];

    // Each byte's x9/x11/x13/x14 multiples, built from its x2/x4/x8 chain.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [7:0] x2, x4, x8;
            a[r]   = col_in[COL_W-1-8*r -: 8];
            x2     = xtime(a[r]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[r]  = x8 ^ a[r];
            m11[r] = x8 ^ x2 ^ a[r];
            m13[r] = x8 ^ x4 ^ a[r];
            m14[r] = x8 ^ x4 ^ x2;
        end
    end

    assign col_out = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                      m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                      m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                      m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};

endmodule

// File: rtl/aes_inv_mix_column_stage.sv
// AddRoundKey + InvMixColumns stage with valid/ready handshake.
// Define AES_INV_MIXCOL_PARALLEL_EN to mix all four columns in a single cycle.
module aes_inv_mix_column_stage
    import aes_inv_mix_column_stage_pkg::*;
(
    input  logic               inClk,
    input  logic               inRstN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [BLOCK_W-1:0] inData,
    input  logic [BLOCK_W-1:0] inKey,
    input  logic               inLast,
    output logic               outValid,
    input  logic               outReady,
    output logic [BLOCK_W-1:0] outData
);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [BLOCK_W-1:0] mixed_block;
    logic               load;

`ifdef AES_INV_MIXCOL_PARALLEL_EN
    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
        AesMultDAFun u_mult (
            .col_in  (data_q[BLOCK_W-1-COL_W*g -: COL_W]),
            .col_out (mixed_block[BLOCK_W-1-COL_W*g -: COL_W])
        );
    end
`else
    logic [COL_CNT_W-1:0] col_q, col_d;
    logic [COL_W-1:0]     col_in, col_out;

    always_comb begin
        col_in = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == c[COL_CNT_W-1:0]) col_in = data_q[BLOCK_W-1-COL_W*c -: COL_W];
        end
    end

    AesMultDAFun u_mult (
        .col_in  (col_in),
        .col_out (col_out)
    );

    // Only the column selected by col is replaced; the rest pass through.
    always_comb begin
        mixed_block = data_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_q == c[COL_CNT_W-1:0]) mixed_block[BLOCK_W-1-COL_W*c -: COL_W] = col_out;
        end
    end

    always_comb begin
        col_d = col_q;
        if (load) col_d = '0;
        else if (state_q == MIX) col_d = col_q + 1'b1;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) col_q <= '0;
        else         col_q <= col_d;
    end
`endif

    // A new block can enter from IDLE, or from DONE in the same cycle the old one leaves.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        inReady = (state_q == IDLE) || ((state_q == DONE) && outReady);
        load    = inValid && inReady;
        case (state_q)
            IDLE: ;
            MIX: begin
                data_d = mixed_block;
`ifdef AES_INV_MIXCOL_PARALLEL_EN
                state_d = DONE;
`else
                if (col_q == COL_CNT_W'(NUM_COLS - 1)) state_d = DONE;
`endif
            end
            DONE: if (outReady && !inValid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d  = inData ^ inKey;
            state_d = inLast ? DONE : MIX;
        end
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign outValid = (state_q == DONE);
    assign outData  = data_q;

endmodule

// File: tb/tb_aes_inv_mix_column_stage.sv
// Directed and random-stream bench for aes_inv_mix_column_stage (serial or AES_INV_MIXCOL_PARALLEL_EN build).
module tb_aes_inv_mix_column_stage;

    logic         inClk = 1'b0;
    logic         inRstN;
    logic         inValid;
    logic         inReady;
    logic [127:0] inData;
    logic [127:0] inKey;
    logic         inLast;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Edges from the accept edge to the first cycle with outValid high.
`ifdef AES_INV_MIXCOL_PARALLEL_EN
    localparam int MIX_LAT = 2;
`else
    localparam int MIX_LAT = 5;
`endif
    localparam int LAST_LAT = 1;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
        logic [127:0] expected;
    } vec_t;

    vec_t vecs[7];

    aes_inv_mix_column_stage dut (
        .inClk    (inClk),
        .inRstN   (inRstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .inKey    (inKey),
        .inLast   (inLast),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData)
    );

    always #5 inClk = ~inClk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] refBlock(input logic [127:0] d, input logic [127:0] k, input logic l);
        logic [127:0] s = d ^ k;
        logic [127:0] r = s;
        logic [7:0]   b [4];
        if (!l) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) b[j] = s[127-32*c-8*j -: 8];
                r[127-32*c -: 32] = {
                    gmul(b[0], 8'h0e) ^ gmul(b[1], 8'h0b) ^ gmul(b[2], 8'h0d) ^ gmul(b[3], 8'h09),
                    gmul(b[0], 8'h09) ^ gmul(b[1], 8'h0e) ^ gmul(b[2], 8'h0b) ^ gmul(b[3], 8'h0d),
                    gmul(b[0], 8'h0d) ^ gmul(b[1], 8'h09) ^ gmul(b[2], 8'h0e) ^ gmul(b[3], 8'h0b),
                    gmul(b[0], 8'h0b) ^ gmul(b[1], 8'h0d) ^ gmul(b[2], 8'h09) ^ gmul(b[3], 8'h0e)};
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for inReady at a falling edge, offers the block, returns just after the accept edge.
    task automatic applyStimulus(input logic [127:0] d, input logic [127:0] k, input logic l);
        int wait_cnt = 0;
        @(negedge inClk);
        while (!inReady && wait_cnt < 20) begin
            @(negedge inClk);
            wait_cnt++;
        end
        checkOutput("inReady before offer", {127'd0, inReady}, 128'd1);
        inValid = 1'b1;
        inData  = d;
        inKey   = k;
        inLast  = l;
        @(posedge inClk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitOutput(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge inClk);
            if (outValid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        logic [127:0] held;
        logic [127:0] exp_q[$];
        int           sent;
        int           got;
        logic         accepted;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b0,
                    128'hdb135345_f20a225c_01010101_d4d4d4d5};
        vecs[1] = '{128'h0, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0,
                    128'hdb135345_f20a225c_01010101_d4d4d4d5};
        vecs[2] = '{{16{8'ha5}}, {16{8'ha5}}, 1'b1, 128'h0};
        vecs[3] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'h0, 1'b0,
                    128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vecs[4] = '{128'hfb997e1a_1f34e665_b7072c85_d7f9d9b3, {16{8'hff}}, 1'b0,
                    128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vecs[5] = '{128'h01234567_89abcdef_fedcba98_76543210, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                    128'h01326754_cdfeab98_76451023_ba89dcef};
        vecs[6] = '{{16{8'hc6}}, 128'h0, 1'b0, {16{8'hc6}}};

        inRstN   = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inKey    = '0;
        inLast   = 1'b0;
        outReady = 1'b1;

        repeat (2) @(negedge inClk);
        checkOutput("reset outValid", {127'd0, outValid}, 128'd0);
        checkOutput("reset outData", outData, 128'd0);
        inRstN = 1'b1;
        @(negedge inClk);
        checkOutput("post-reset inReady", {127'd0, inReady}, 128'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].data, vecs[i].key, vecs[i].last);
            waitOutput(lat);
            checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].last ? LAST_LAT : MIX_LAT));
            checkOutput($sformatf("vec%0d data", i), outData, vecs[i].expected);
            @(posedge inClk);
            #1;
        end

        // Backpressure: output held for 10 cycles, then output and new input handshake together.
        outReady = 1'b0;
        applyStimulus(vecs[0].data, vecs[0].key, vecs[0].last);
        waitOutput(lat);
        held = outData;
        checkOutput("bp data", held, vecs[0].expected);
        for (int n = 0; n < 10; n++) begin
            @(negedge inClk);
            checkOutput($sformatf("bp hold %0d", n), {outValid, inReady, outData},
                        {1'b1, 1'b0, vecs[0].expected});
        end
        @(negedge inClk);
        outReady = 1'b1;
        inValid  = 1'b1;
        inData   = vecs[5].data;
        inKey    = vecs[5].key;
        inLast   = vecs[5].last;
        #1;
        checkOutput("bp inReady on release", {127'd0, inReady}, 128'd1);
        @(posedge inClk);
        #1;
        inValid = 1'b0;
        @(negedge inClk);
        checkOutput("bp next block", {outValid, outData}, {1'b1, vecs[5].expected});
        @(posedge inClk);
        #1;

        // Reset while column 2 is being mixed.
        applyStimulus(vecs[3].data, vecs[3].key, vecs[3].last);
        @(posedge inClk);
        @(posedge inClk);
        @(negedge inClk);
        inRstN = 1'b0;
        #1;
        checkOutput("mid reset outData", outData, 128'd0);
        @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
        checkOutput("after reset flags", {126'd0, outValid, inReady}, 128'd1);
        checkOutput("after reset outData", outData, 128'd0);
        applyStimulus(vecs[3].data, vecs[3].key, vecs[3].last);
        waitOutput(lat);
        checkOutput("after reset latency", 128'(lat), 128'(MIX_LAT));
        checkOutput("after reset data", outData, vecs[3].expected);
        @(posedge inClk);
        #1;

        // Random stream with random backpressure, checked in order against the model.
        sent     = 0;
        got      = 0;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
            @(negedge inClk);
            if (accepted) inValid = 1'b0;
            if (!inValid && sent < 8) begin
                inValid = 1'b1;
                inData  = {$urandom, $urandom, $urandom, $urandom};
                inKey   = {$urandom, $urandom, $urandom, $urandom};
                inLast  = 1'($urandom_range(0, 1));
            end
            outReady = 1'($urandom_range(0, 1));
            #1;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream unexpected output", outData, 128'hx);
                end else begin
                    checkOutput($sformatf("stream block %0d", got), outData, exp_q.pop_front());
                end
                got++;
            end
            accepted = inValid && inReady;
            if (accepted) begin
                exp_q.push_back(refBlock(inData, inKey, inLast));
                sent++;
            end
        end
        inValid = 1'b0;
        checkOutput("stream blocks out", 128'(got), 128'd8);
        checkOutput("stream leftover", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
